// File: rtl/mult4_share_sequencer.sv
// Round-robin front end that time-shares one external 4x4 multiplier to build WxW products.
// Optional zero-operand shortcut selected by defining MULT_BYPASS_EN.
module mult4_share_sequencer #(
   parameter int unsigned W         = 8,
   parameter bit          INIT_PRIO = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           s0_valid,
   output logic           s0_ready,
   input  logic [W-1:0]   s0_a,
   input  logic [W-1:0]   s0_b,
   input  logic           s1_valid,
   output logic           s1_ready,
   input  logic [W-1:0]   s1_a,
   input  logic [W-1:0]   s1_b,
   output logic           m_valid,
   input  logic           m_ready,
   output logic [2*W-1:0] m_prod,
   output logic           m_id,
   output logic           busy,
   output logic [3:0]     mu_m,
   output logic [3:0]     mu_q,
   input  logic [7:0]     mu_p
);

   localparam int unsigned N      = W / 4;
   localparam int unsigned PASSES = N * N;
   localparam int unsigned PW     = $clog2(PASSES + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t         state;
   state_t         state_nxt;
   logic           prio;
   logic           id_r;
   logic           gnt;
   logic           accept;
   logic           zero_op;
   logic           last_pass;
   logic [W-1:0]   a_r;
   logic [W-1:0]   b_r;
   logic [W-1:0]   sel_a;
   logic [W-1:0]   sel_b;
   logic [2*W-1:0] acc;
   logic [2*W-1:0] acc_nxt;
   logic [PW-1:0]  pass;
   int unsigned    nib_i;
   int unsigned    nib_j;

   // Request arbitration: a lone requester wins, a tie goes to prio.
   always_comb begin
      gnt = 1'b0;
      if (s0_valid && s1_valid)
         gnt = prio;
      else if (s1_valid)
         gnt = 1'b1;
      accept = (state == IDLE) && !rst && (s0_valid || s1_valid);
      sel_a  = gnt ? s1_a : s0_a;
      sel_b  = gnt ? s1_b : s0_b;
   end

`ifdef MULT_BYPASS_EN
   assign zero_op = (sel_a == '0) || (sel_b == '0);
`else
   assign zero_op = 1'b0;
`endif

   // Pass k walks a-nibbles in the outer loop and b-nibbles in the inner loop.
   always_comb begin
      nib_i     = 32'(pass) / N;
      nib_j     = 32'(pass) % N;
      last_pass = (pass == PW'(PASSES - 1));
      acc_nxt   = acc + ((2*W)'(mu_p) << (4 * (nib_i + nib_j)));
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept)    state_nxt = zero_op ? DONE : CALC;
         CALC: if (last_pass) state_nxt = DONE;
         DONE: if (m_ready)   state_nxt = IDLE;
         default:             state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s0_ready = 1'b0;
      s1_ready = 1'b0;
      mu_m     = '0;
      mu_q     = '0;
      busy     = (state != IDLE);
      case (state)
         IDLE: begin
            s0_ready = accept && !gnt;
            s1_ready = accept && gnt;
         end
         CALC: begin
            mu_m = 4'(a_r >> (4 * nib_i));
            mu_q = 4'(b_r >> (4 * nib_j));
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio    <= INIT_PRIO;
         id_r    <= 1'b0;
         a_r     <= '0;
         b_r     <= '0;
         acc     <= '0;
         pass    <= '0;
         m_valid <= 1'b0;
         m_prod  <= '0;
         m_id    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_r  <= sel_a;
                  b_r  <= sel_b;
                  id_r <= gnt;
                  acc  <= '0;
                  pass <= '0;
                  prio <= ~gnt;
                  if (zero_op) begin
                     m_prod  <= '0;
                     m_id    <= gnt;
                     m_valid <= 1'b1;
                  end
               end
            end
            CALC: begin
               acc  <= acc_nxt;
               pass <= pass + PW'(1);
               if (last_pass) begin
                  m_prod  <= acc_nxt;
                  m_id    <= id_r;
                  m_valid <= 1'b1;
               end
            end
            DONE: begin
               if (m_ready)
                  m_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
